// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// decode_pkg : opcode, ALU and immediate encodings plus the per-lane control bundle
// Revision   : 1.0
// ============================================================================
package decode_pkg;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;

   typedef struct packed {
      logic       regwrite;
      logic       alusrc;
      logic       memwrite;
      logic       resultsrc;
      logic       branch;
      logic       illegal;
      logic [2:0] alucontrol;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // subBit is funct7[5] for R-type; I-type callers pass 0 since there is no subi
   function automatic logic [2:0] aluDecode(input logic [2:0] funct3, input logic subBit);
      logic [2:0] op;
      case (funct3)
         3'b000:  op = subBit ? ALU_SUB : ALU_ADD;
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_nlane_lane.sv
`default_nettype none
// ============================================================================
// decode_lane : combinational control decode and immediate extension, one lane
// Revision    : 1.0
// ============================================================================
module decode_lane
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic [31:0]       instr,
   input  logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [XLEN-1:0]   imm,
   output logic [AW-1:0]     rs1,
   output logic [AW-1:0]     rs2,
   output logic [AW-1:0]     rd
);

   ctrl_t       w_ctrl;
   logic [1:0]  w_immSrc;
   logic [12:0] w_imm13;

   always_comb begin
      w_ctrl   = '0;
      w_immSrc = IMM_I;
      case (instr[6:0])
         OP_LW: begin
            w_ctrl.regwrite  = 1'b1;
            w_ctrl.alusrc    = 1'b1;
            w_ctrl.resultsrc = 1'b1;
         end
         OP_SW: begin
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.memwrite = 1'b1;
            w_immSrc        = IMM_S;
         end
         OP_R: begin
            w_ctrl.regwrite   = 1'b1;
            w_ctrl.alucontrol = aluDecode(instr[14:12], instr[30]);
         end
         OP_I: begin
            w_ctrl.regwrite   = 1'b1;
            w_ctrl.alusrc     = 1'b1;
            w_ctrl.alucontrol = aluDecode(instr[14:12], 1'b0);
         end
         OP_B: begin
            w_ctrl.branch     = 1'b1;
            w_ctrl.alucontrol = ALU_SUB;
            w_immSrc          = IMM_B;
         end
         default: w_ctrl.illegal = 1'b1;
      endcase
      if (!valid) w_ctrl = '0;
   end

   // Every format is assembled as a 13-bit signed value, then sign-extended once
   always_comb begin
      case (w_immSrc)
         IMM_S:   w_imm13 = {instr[31], instr[31:25], instr[11:7]};
         IMM_B:   w_imm13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: w_imm13 = {instr[31], instr[31:20]};
      endcase
   end

   assign ctrl = w_ctrl;
   assign imm  = {{(XLEN-13){w_imm13[12]}}, w_imm13};
   assign rs1  = instr[15 +: AW];
   assign rs2  = instr[20 +: AW];
   assign rd   = instr[7 +: AW];

endmodule
`default_nettype wire

// File: rtl/decode_stage_nlane.sv
`default_nettype none
// ============================================================================
// decode_stage_nlane : N-lane decode, shared bypassed register file, D->E register
// Revision           : 1.0
// ============================================================================
module decode_stage_nlane
   import decode_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int XLEN      = 32,
   parameter int NREG      = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_LANES*32-1:0]            instr_d,
   input  logic [NUM_LANES*XLEN-1:0]          pc_d,
   input  logic [NUM_LANES*XLEN-1:0]          pc_plus4_d,
   input  logic [NUM_LANES-1:0]               valid_d,
   input  logic                               hold_i,
   input  logic                               flush_i,
   input  logic [NUM_LANES-1:0]               regwrite_w,
   input  logic [NUM_LANES*$clog2(NREG)-1:0]  rd_w,
   input  logic [NUM_LANES*XLEN-1:0]          result_w,
   output logic                               load_use_stall_o,
   output logic [NUM_LANES-1:0]               valid_e,
   output logic [NUM_LANES-1:0]               regwrite_e,
   output logic [NUM_LANES-1:0]               alusrc_e,
   output logic [NUM_LANES-1:0]               memwrite_e,
   output logic [NUM_LANES-1:0]               resultsrc_e,
   output logic [NUM_LANES-1:0]               branch_e,
   output logic [NUM_LANES-1:0]               illegal_e,
   output logic [NUM_LANES*3-1:0]             alucontrol_e,
   output logic [NUM_LANES*XLEN-1:0]          rd1_e,
   output logic [NUM_LANES*XLEN-1:0]          rd2_e,
   output logic [NUM_LANES*XLEN-1:0]          imm_e,
   output logic [NUM_LANES*$clog2(NREG)-1:0]  rs1_e,
   output logic [NUM_LANES*$clog2(NREG)-1:0]  rs2_e,
   output logic [NUM_LANES*$clog2(NREG)-1:0]  rd_e,
   output logic [NUM_LANES*XLEN-1:0]          pc_e,
   output logic [NUM_LANES*XLEN-1:0]          pc_plus4_e
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] r_regs [NREG];
   ctrl_t           w_ctrl [NUM_LANES];
   logic [XLEN-1:0] w_imm  [NUM_LANES];
   logic [XLEN-1:0] w_rd1  [NUM_LANES];
   logic [XLEN-1:0] w_rd2  [NUM_LANES];
   logic [AW-1:0]   w_rs1  [NUM_LANES];
   logic [AW-1:0]   w_rs2  [NUM_LANES];
   logic [AW-1:0]   w_rd   [NUM_LANES];
   logic            w_stall;
   logic            w_bubble;

   // Later lanes overwrite earlier ones, so the highest-index writer wins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++)
            if (regwrite_w[l] && rd_w[l*AW +: AW] != '0)
               r_regs[rd_w[l*AW +: AW]] <= result_w[l*XLEN +: XLEN];
      end
   end

   generate
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
         logic [XLEN-1:0] g_rd1;
         logic [XLEN-1:0] g_rd2;

         decode_lane #(.XLEN(XLEN), .AW(AW)) u_lane (
            .instr (instr_d[l*32 +: 32]),
            .valid (valid_d[l]),
            .ctrl  (w_ctrl[l]),
            .imm   (w_imm[l]),
            .rs1   (w_rs1[l]),
            .rs2   (w_rs2[l]),
            .rd    (w_rd[l])
         );

         // Same-cycle writeback bypass; x0 is forced last so it always reads 0
         always_comb begin
            g_rd1 = r_regs[w_rs1[l]];
            g_rd2 = r_regs[w_rs2[l]];
            for (int w = 0; w < NUM_LANES; w++) begin
               if (regwrite_w[w] && rd_w[w*AW +: AW] == w_rs1[l]) g_rd1 = result_w[w*XLEN +: XLEN];
               if (regwrite_w[w] && rd_w[w*AW +: AW] == w_rs2[l]) g_rd2 = result_w[w*XLEN +: XLEN];
            end
            if (w_rs1[l] == '0) g_rd1 = '0;
            if (w_rs2[l] == '0) g_rd2 = '0;
         end

         assign w_rd1[l] = g_rd1;
         assign w_rd2[l] = g_rd2;
      end
   endgenerate

   always_comb begin
      w_stall = 1'b0;
      for (int j = 0; j < NUM_LANES; j++)
         for (int i = 0; i < NUM_LANES; i++)
            if (valid_e[j] && resultsrc_e[j] && regwrite_e[j] && rd_e[j*AW +: AW] != '0 &&
                valid_d[i] && (rd_e[j*AW +: AW] == w_rs1[i] || rd_e[j*AW +: AW] == w_rs2[i]))
               w_stall = 1'b1;
      if (flush_i) w_stall = 1'b0;
   end

   assign load_use_stall_o = w_stall;
   // Flush beats hold; hold beats the load-use bubble
   assign w_bubble = flush_i || (!hold_i && w_stall);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, illegal_e} <= '0;
         {alucontrol_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e}     <= '0;
      end else if (w_bubble) begin
         {valid_e, regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, illegal_e} <= '0;
         {alucontrol_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e}     <= '0;
      end else if (!hold_i) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            valid_e[l]                  <= valid_d[l];
            regwrite_e[l]               <= w_ctrl[l].regwrite;
            alusrc_e[l]                 <= w_ctrl[l].alusrc;
            memwrite_e[l]               <= w_ctrl[l].memwrite;
            resultsrc_e[l]              <= w_ctrl[l].resultsrc;
            branch_e[l]                 <= w_ctrl[l].branch;
            illegal_e[l]                <= w_ctrl[l].illegal;
            alucontrol_e[l*3 +: 3]      <= w_ctrl[l].alucontrol;
            rd1_e[l*XLEN +: XLEN]       <= w_rd1[l];
            rd2_e[l*XLEN +: XLEN]       <= w_rd2[l];
            imm_e[l*XLEN +: XLEN]       <= w_imm[l];
            rs1_e[l*AW +: AW]           <= w_rs1[l];
            rs2_e[l*AW +: AW]           <= w_rs2[l];
            rd_e[l*AW +: AW]            <= w_rd[l];
            pc_e[l*XLEN +: XLEN]        <= pc_d[l*XLEN +: XLEN];
            pc_plus4_e[l*XLEN +: XLEN]  <= pc_plus4_d[l*XLEN +: XLEN];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_nlane.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_nlane : directed scoreboard bench for 2-lane and 4-lane decode
// Revision              : 1.0
// ============================================================================
module tb_decode_stage_nlane;

   logic clk = 1'b0;
   logic rst;
   logic hold, flush;
   always #5 clk = ~clk;

   logic [63:0] instr2, pc2, pcp2, result2;
   logic [1:0]  valid2, rw2;
   logic [9:0]  rdw2;
   logic        stall2;
   logic [1:0]  validE2, regwrE2, alusrcE2, memwrE2, ressrcE2, branchE2, illE2;
   logic [5:0]  aluE2;
   logic [63:0] rd1E2, rd2E2, immE2, pcE2, pcp4E2;
   logic [9:0]  rs1E2, rs2E2, rdE2;

   logic [127:0] instr4, pc4, pcp4, result4;
   logic [3:0]   valid4, rw4;
   logic [19:0]  rdw4;
   logic         stall4;
   logic [3:0]   validE4, regwrE4, alusrcE4, memwrE4, ressrcE4, branchE4, illE4;
   logic [11:0]  aluE4;
   logic [127:0] rd1E4, rd2E4, immE4, pcE4, pcp4E4;
   logic [19:0]  rs1E4, rs2E4, rdE4;

   decode_stage_nlane #(.NUM_LANES(2), .XLEN(32), .NREG(32)) dut2 (
      .clk(clk), .rst(rst), .instr_d(instr2), .pc_d(pc2), .pc_plus4_d(pcp2), .valid_d(valid2),
      .hold_i(hold), .flush_i(flush), .regwrite_w(rw2), .rd_w(rdw2), .result_w(result2),
      .load_use_stall_o(stall2), .valid_e(validE2), .regwrite_e(regwrE2), .alusrc_e(alusrcE2),
      .memwrite_e(memwrE2), .resultsrc_e(ressrcE2), .branch_e(branchE2), .illegal_e(illE2),
      .alucontrol_e(aluE2), .rd1_e(rd1E2), .rd2_e(rd2E2), .imm_e(immE2), .rs1_e(rs1E2),
      .rs2_e(rs2E2), .rd_e(rdE2), .pc_e(pcE2), .pc_plus4_e(pcp4E2));

   decode_stage_nlane #(.NUM_LANES(4), .XLEN(32), .NREG(32)) dut4 (
      .clk(clk), .rst(rst), .instr_d(instr4), .pc_d(pc4), .pc_plus4_d(pcp4), .valid_d(valid4),
      .hold_i(1'b0), .flush_i(1'b0), .regwrite_w(rw4), .rd_w(rdw4), .result_w(result4),
      .load_use_stall_o(stall4), .valid_e(validE4), .regwrite_e(regwrE4), .alusrc_e(alusrcE4),
      .memwrite_e(memwrE4), .resultsrc_e(ressrcE4), .branch_e(branchE4), .illegal_e(illE4),
      .alucontrol_e(aluE4), .rd1_e(rd1E4), .rd2_e(rd2E4), .imm_e(immE4), .rs1_e(rs1E4),
      .rs2_e(rs2E4), .rd_e(rdE4), .pc_e(pcE4), .pc_plus4_e(pcp4E4));

   typedef enum int {F_VALID, F_REGWR, F_ALUSRC, F_MEMWR, F_RESSRC, F_BRANCH, F_ILL, F_ALU,
                     F_RD1, F_RD2, F_IMM, F_RS1, F_RS2, F_RD, F_PC, F_PCP4, F_STALL} fld_t;
   typedef struct {int d; fld_t f; int l; logic [31:0] exp; string tag;} item_t;

   item_t sb[$];
   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] obs(int d, fld_t f, int l);
      logic [31:0] r;
      r = 32'hBAD0BAD0;
      if (d == 2) begin
         case (f)
            F_VALID:  r = {31'b0, validE2[l]};
            F_REGWR:  r = {31'b0, regwrE2[l]};
            F_ALUSRC: r = {31'b0, alusrcE2[l]};
            F_MEMWR:  r = {31'b0, memwrE2[l]};
            F_RESSRC: r = {31'b0, ressrcE2[l]};
            F_BRANCH: r = {31'b0, branchE2[l]};
            F_ILL:    r = {31'b0, illE2[l]};
            F_ALU:    r = {29'b0, aluE2[l*3 +: 3]};
            F_RD1:    r = rd1E2[l*32 +: 32];
            F_RD2:    r = rd2E2[l*32 +: 32];
            F_IMM:    r = immE2[l*32 +: 32];
            F_RS1:    r = {27'b0, rs1E2[l*5 +: 5]};
            F_RS2:    r = {27'b0, rs2E2[l*5 +: 5]};
            F_RD:     r = {27'b0, rdE2[l*5 +: 5]};
            F_PC:     r = pcE2[l*32 +: 32];
            F_PCP4:   r = pcp4E2[l*32 +: 32];
            F_STALL:  r = {31'b0, stall2};
            default:  r = 32'hBAD0BAD0;
         endcase
      end else begin
         case (f)
            F_VALID:  r = {31'b0, validE4[l]};
            F_MEMWR:  r = {31'b0, memwrE4[l]};
            F_IMM:    r = immE4[l*32 +: 32];
            F_RD1:    r = rd1E4[l*32 +: 32];
            F_RD:     r = {27'b0, rdE4[l*5 +: 5]};
            F_STALL:  r = {31'b0, stall4};
            default:  r = 32'hBAD0BAD0;
         endcase
      end
      return r;
   endfunction

   task automatic push(int d, fld_t f, int l, logic [31:0] e, string tag);
      item_t it;
      it.d = d; it.f = f; it.l = l; it.exp = e; it.tag = tag;
      sb.push_back(it);
   endtask

   task automatic drain();
      item_t it;
      logic [31:0] got;
      while (sb.size() > 0) begin
         it  = sb.pop_front();
         got = obs(it.d, it.f, it.l);
         tests++;
         assert (got === it.exp) else begin
            fails++;
            $error("FAIL %s lane%0d observed=%h expected=%h", it.tag, it.l, got, it.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic settle();
      #1;
      drain();
   endtask

   task automatic setLane2(int l, logic [31:0] ins);
      instr2[l*32 +: 32] = ins;
      pc2[l*32 +: 32]    = 32'h100 + 32'(l*4);
      pcp2[l*32 +: 32]   = 32'h104 + 32'(l*4);
   endtask

   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      logic [31:0] iv = imm;
      return {iv[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
   endfunction
   function automatic logic [31:0] lw(int rd, int rs1, int imm);
      logic [31:0] iv = imm;
      return {iv[11:0], 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
   endfunction
   function automatic logic [31:0] sw(int rs2, int rs1, int imm);
      logic [31:0] iv = imm;
      return {iv[11:5], 5'(rs2), 5'(rs1), 3'b010, iv[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] rtype(logic [6:0] f7, int rd, int rs1, int rs2, logic [2:0] f3);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] beq(int rs1, int rs2, int imm);
      logic [31:0] iv = imm;
      return {iv[12], iv[10:5], 5'(rs2), 5'(rs1), 3'b000, iv[4:1], iv[11], 7'b1100011};
   endfunction

   initial begin
      rst = 1'b0; hold = 1'b0; flush = 1'b0;
      instr2 = '0; pc2 = '0; pcp2 = '0; valid2 = '0; rw2 = '0; rdw2 = '0; result2 = '0;
      instr4 = '0; pc4 = '0; pcp4 = '0; valid4 = '0; rw4 = '0; rdw4 = '0; result4 = '0;
      #2;
      push(2, F_VALID, 0, 0, "rst_valid"); push(2, F_VALID, 1, 0, "rst_valid");
      push(2, F_REGWR, 0, 0, "rst_regwrite"); push(2, F_IMM, 1, 0, "rst_imm");
      push(2, F_RD, 0, 0, "rst_rd"); push(4, F_VALID, 3, 0, "rst_valid4");
      drain();
      #1 rst = 1'b1;

      // addi / sw issue
      setLane2(0, addi(1, 0, 5)); setLane2(1, sw(2, 3, 8)); valid2 = 2'b11;
      push(2, F_VALID, 0, 1, "addi_valid"); push(2, F_IMM, 0, 5, "addi_imm");
      push(2, F_REGWR, 0, 1, "addi_regwrite"); push(2, F_ALUSRC, 0, 1, "addi_alusrc");
      push(2, F_ALU, 0, 0, "addi_alu"); push(2, F_RD, 0, 1, "addi_rd");
      push(2, F_PC, 0, 32'h100, "addi_pc"); push(2, F_PCP4, 1, 32'h108, "sw_pcp4");
      push(2, F_MEMWR, 1, 1, "sw_memwrite"); push(2, F_IMM, 1, 8, "sw_imm");
      push(2, F_REGWR, 1, 0, "sw_regwrite"); push(2, F_RS1, 1, 3, "sw_rs1");
      push(2, F_RS2, 1, 2, "sw_rs2");
      tick();

      // W->D bypass of x4, negative immediate
      rw2 = 2'b01; rdw2 = {5'd0, 5'd4}; result2 = {32'h0, 32'hDEAD};
      setLane2(0, addi(9, 0, -3)); setLane2(1, rtype(7'b0, 8, 4, 4, 3'b000));
      push(2, F_RD1, 1, 32'hDEAD, "bypass_rd1"); push(2, F_RD2, 1, 32'hDEAD, "bypass_rd2");
      push(2, F_IMM, 0, 32'hFFFF_FFFD, "neg_imm"); push(2, F_ALU, 1, 0, "add_alu");
      tick();
      rw2 = 2'b00;
      setLane2(0, rtype(7'b0, 10, 4, 0, 3'b000));
      push(2, F_RD1, 0, 32'hDEAD, "regfile_x4");
      tick();

      // both lanes write x4: lane1 wins
      rw2 = 2'b11; rdw2 = {5'd4, 5'd4}; result2 = {32'h2, 32'h1};
      push(2, F_RD1, 0, 32'h2, "dualwr_bypass");
      tick();
      rw2 = 2'b00;
      push(2, F_RD1, 0, 32'h2, "dualwr_stored");
      tick();

      // x0 write ignored, bypass suppressed; SLT decode
      rw2 = 2'b01; rdw2 = {5'd0, 5'd0}; result2 = {32'h0, 32'hFFFF};
      setLane2(0, rtype(7'b0, 11, 0, 0, 3'b000)); setLane2(1, rtype(7'b0, 7, 1, 2, 3'b010));
      push(2, F_RD1, 0, 0, "x0_bypass"); push(2, F_ALU, 1, 3'b101, "slt_alu");
      tick();
      rw2 = 2'b00;
      push(2, F_RD1, 0, 0, "x0_read");
      tick();

      // branch and OR decode
      setLane2(0, beq(1, 2, -8)); setLane2(1, rtype(7'b0, 3, 1, 2, 3'b110));
      push(2, F_IMM, 0, 32'hFFFF_FFF8, "beq_imm"); push(2, F_BRANCH, 0, 1, "beq_branch");
      push(2, F_ALU, 0, 3'b001, "beq_alu"); push(2, F_REGWR, 0, 0, "beq_regwrite");
      push(2, F_ALU, 1, 3'b011, "or_alu");
      tick();
      setLane2(0, rtype(7'b0100000, 3, 1, 2, 3'b000));
      push(2, F_ALU, 0, 3'b001, "sub_alu");
      tick();

      // illegal opcode, valid and invalid lane
      setLane2(0, 32'h0000_007F); setLane2(1, 32'h0000_007F); valid2 = 2'b01;
      push(2, F_ILL, 0, 1, "ill_flag"); push(2, F_REGWR, 0, 0, "ill_regwrite");
      push(2, F_MEMWR, 0, 0, "ill_memwrite"); push(2, F_VALID, 0, 1, "ill_valid");
      push(2, F_ILL, 1, 0, "inv_ill"); push(2, F_VALID, 1, 0, "inv_valid");
      tick();

      // load-use: lw x5 in E, add x6,x5,x7 in D
      valid2 = 2'b11;
      setLane2(0, lw(5, 0, 0)); setLane2(1, addi(12, 0, 1));
      push(2, F_RESSRC, 0, 1, "lw_resultsrc");
      tick();
      setLane2(0, addi(13, 0, 0)); setLane2(1, rtype(7'b0, 6, 5, 7, 3'b000));
      push(2, F_STALL, 0, 1, "lu_stall");
      settle();
      push(2, F_VALID, 0, 0, "lu_bubble"); push(2, F_VALID, 1, 0, "lu_bubble");
      tick();
      push(2, F_STALL, 0, 0, "lu_clear");
      settle();
      push(2, F_VALID, 1, 1, "lu_issue"); push(2, F_RD, 1, 6, "lu_issue_rd");
      tick();

      // hold for 3 cycles with a new D bundle
      hold = 1'b1;
      setLane2(0, addi(20, 0, 99)); setLane2(1, addi(21, 0, 99));
      for (int c = 0; c < 3; c++) begin
         push(2, F_VALID, 1, 1, "hold_valid"); push(2, F_RD, 0, 13, "hold_rd0");
         push(2, F_RD, 1, 6, "hold_rd1"); push(2, F_IMM, 0, 0, "hold_imm0");
         tick();
      end

      // asynchronous reset while held
      #2 rst = 1'b0;
      push(2, F_VALID, 1, 0, "arst_valid"); push(2, F_RD, 1, 0, "arst_rd1");
      push(2, F_IMM, 1, 0, "arst_imm");
      settle();
      #1 rst = 1'b1;
      hold = 1'b0;

      // flush+hold bubbles; flush masks the stall
      setLane2(0, lw(5, 0, 0)); setLane2(1, addi(12, 0, 1));
      push(2, F_VALID, 0, 1, "pre_flush_valid");
      tick();
      setLane2(0, addi(13, 0, 0)); setLane2(1, rtype(7'b0, 6, 5, 7, 3'b000));
      flush = 1'b1; hold = 1'b1;
      push(2, F_STALL, 0, 0, "flush_mask_stall");
      settle();
      push(2, F_VALID, 0, 0, "flush_hold"); push(2, F_VALID, 1, 0, "flush_hold");
      tick();
      flush = 1'b0; hold = 1'b0;

      // hold wins over the stall, bubble follows once hold drops
      setLane2(0, lw(5, 0, 0)); setLane2(1, addi(12, 0, 1));
      tick();
      setLane2(0, addi(13, 0, 0)); setLane2(1, rtype(7'b0, 6, 5, 7, 3'b000));
      hold = 1'b1;
      push(2, F_STALL, 0, 1, "hold_stall");
      settle();
      push(2, F_VALID, 0, 1, "hold_wins"); push(2, F_RD, 0, 5, "hold_wins_rd");
      tick();
      hold = 1'b0;
      push(2, F_VALID, 0, 0, "post_hold_bubble");
      tick();

      // 4-lane: indexing and highest-lane writer wins among 0..3
      valid4 = 4'b1111;
      instr4 = {rtype(7'b0, 15, 4, 0, 3'b000), addi(14, 0, -1), sw(2, 3, 8), addi(1, 0, 5)};
      rw4 = 4'b1111; rdw4 = {5'd4, 5'd4, 5'd4, 5'd4};
      result4 = {32'h4, 32'h3, 32'h2, 32'h1};
      push(4, F_IMM, 0, 5, "n4_imm0"); push(4, F_IMM, 1, 8, "n4_imm1");
      push(4, F_MEMWR, 1, 1, "n4_memwrite1"); push(4, F_IMM, 2, 32'hFFFF_FFFF, "n4_imm2");
      push(4, F_RD1, 3, 4, "n4_bypass"); push(4, F_RD, 3, 15, "n4_rd3");
      push(4, F_VALID, 3, 1, "n4_valid3");
      tick();
      rw4 = 4'b0000;
      instr4[31:0] = rtype(7'b0, 16, 4, 0, 3'b000);
      push(4, F_RD1, 0, 4, "n4_stored");
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
